// File: rtl/sfifo_pkt_wr_control_if.sv
// Packet write-side bundle between the packet source and the sfifo packet write controller.
// The master modport is the source side and the slave modport is the controller.
interface sfifo_pkt_wr_control_if #(
    parameter int unsigned AddrLines = 8
);
    logic                 FIFOWrReq;
    logic                 WrSop;
    logic                 WrEop;
    logic                 WrAbort;
    logic [AddrLines:0]   SyncRdAddr;
    logic                 WrEn;
    logic [AddrLines-1:0] WrAddr;
    logic [AddrLines:0]   CommitWrAddr;
    logic                 FIFOFull;
    logic                 PktDropped;
    logic                 FramingErr;
    logic [AddrLines:0]   WrLevel;
    logic                 AlmostFull;

    modport master (
        output FIFOWrReq, WrSop, WrEop, WrAbort, SyncRdAddr,
        input  WrEn, WrAddr, CommitWrAddr, FIFOFull, PktDropped, FramingErr, WrLevel, AlmostFull
    );

    modport slave (
        input  FIFOWrReq, WrSop, WrEop, WrAbort, SyncRdAddr,
        output WrEn, WrAddr, CommitWrAddr, FIFOFull, PktDropped, FramingErr, WrLevel, AlmostFull
    );
endinterface

// File: rtl/sfifo_pkt_wr_control.sv
// Packet-mode write controller: speculative writes, commit on EOP, rewind on abort/overflow.
// Define SFIFO_WR_LEVEL_EN to enable the WrLevel / AlmostFull outputs.
module sfifo_pkt_wr_control #(
    parameter int unsigned AddrLines   = 8,
    parameter int unsigned AFullThresh = (2 ** AddrLines) - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sfifo_pkt_wr_control_if.slave bus
);
    localparam int unsigned PtrW = AddrLines + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PKT  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] commit_q, commit_d;
    logic            pkt_dropped_q, pkt_dropped_d;
    logic            framing_err_q, framing_err_d;
    logic            full_c;
    logic            wr_en_c;
    logic [PtrW-1:0] level_c;
    logic            afull_c;

    // Full counts speculative words as occupied.
    assign full_c  = (wr_ptr_q == {~bus.SyncRdAddr[AddrLines], bus.SyncRdAddr[AddrLines-1:0]});
    assign wr_en_c = bus.FIFOWrReq & ~full_c & ~bus.WrAbort &
                     ((state_q == S_PKT) | ((state_q == S_IDLE) & bus.WrSop));

`ifdef SFIFO_WR_LEVEL_EN
    assign level_c = wr_ptr_q - bus.SyncRdAddr;
    assign afull_c = (level_c >= PtrW'(AFullThresh));
`else
    assign level_c = '0;
    assign afull_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            commit_q      <= '0;
            pkt_dropped_q <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_q      <= commit_d;
            pkt_dropped_q <= pkt_dropped_d;
            framing_err_q <= framing_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_en_c ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
        commit_d      = commit_q;
        pkt_dropped_d = 1'b0;
        framing_err_d = framing_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.FIFOWrReq && !bus.WrAbort) begin
                    if (!bus.WrSop) begin
                        framing_err_d = 1'b1;
                    end else if (full_c) begin
                        pkt_dropped_d = 1'b1;
                        if (!bus.WrEop) state_d = S_DROP;
                    end else if (bus.WrEop) begin
                        commit_d = wr_ptr_q + PtrW'(1);
                    end else begin
                        state_d = S_PKT;
                    end
                end
            end
            S_PKT: begin
                if (bus.WrAbort) begin
                    wr_ptr_d      = commit_q;
                    pkt_dropped_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (bus.FIFOWrReq) begin
                    if (bus.WrSop) framing_err_d = 1'b1;
                    // Overflow discards the whole packet, including words already written.
                    if (full_c) begin
                        wr_ptr_d      = commit_q;
                        pkt_dropped_d = 1'b1;
                        state_d       = bus.WrEop ? S_IDLE : S_DROP;
                    end else if (bus.WrEop) begin
                        commit_d = wr_ptr_q + PtrW'(1);
                        state_d  = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (bus.WrAbort || (bus.FIFOWrReq && bus.WrEop)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.WrEn         = wr_en_c;
    assign bus.WrAddr       = wr_ptr_q[AddrLines-1:0];
    assign bus.CommitWrAddr = commit_q;
    assign bus.FIFOFull     = full_c;
    assign bus.PktDropped   = pkt_dropped_q;
    assign bus.FramingErr   = framing_err_q;
    assign bus.WrLevel      = level_c;
    assign bus.AlmostFull   = afull_c;
endmodule
